// File: rtl/fpdiv_rr_scheduler.sv
// Round-robin share of one fixed-latency divider among N_REQ requesters; optional FPDIV_SCHED_DZ_FLAG_EN adds a divide-by-zero flag.
// Latency: DIV_LATENCY+1 cycles from grant edge to rsp_valid; one issue per cycle sustained.
// Backpressure: requesters hold req_valid/operands until req_ready; responses cannot be stalled.
module fpdiv_rr_scheduler #(
    parameter int N_REQ       = 4,
    parameter int DIV_LATENCY = 8,
    parameter int CNT_W       = $clog2(DIV_LATENCY + 2)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_value1,
    input  logic [32*N_REQ-1:0]   req_value2,
    output logic [31:0]           div_value1,
    output logic [31:0]           div_value2,
    input  logic [31:0]           div_result,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_result,
    output logic                  rsp_dz,
    output logic [CNT_W-1:0]      in_flight
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
`ifdef FPDIV_SCHED_DZ_FLAG_EN
        logic            dz;
`endif
    } tag_t;

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] grant_id;
    logic            grant;
    int              idx;
    logic [31:0]     sel_v1;
    logic [31:0]     sel_v2;
    tag_t            tag_new;
    tag_t            tag_last;
    // Stage 0 is aligned with div_value; stage DIV_LATENCY is aligned with div_result.
    tag_t            tag_pipe [DIV_LATENCY+1];

    always_comb begin
        req_ready = '0;
        grant_id  = '0;
        grant     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ)
                idx = idx - N_REQ;
            if (!grant && req_valid[idx]) begin
                grant    = 1'b1;
                grant_id = ID_W'(idx);
            end
        end
        if (!aresetn)
            grant = 1'b0;
        if (grant)
            req_ready[grant_id] = 1'b1;
    end

    assign sel_v1   = req_value1[32*grant_id +: 32];
    assign sel_v2   = req_value2[32*grant_id +: 32];
    assign tag_last = tag_pipe[DIV_LATENCY];

    always_comb begin
        tag_new     = '0;
        tag_new.vld = grant;
        tag_new.id  = grant_id;
`ifdef FPDIV_SCHED_DZ_FLAG_EN
        // +0 and -0 both count as zero divisors.
        tag_new.dz  = grant && (sel_v2[30:0] == 31'd0);
`endif
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr        <= '0;
            div_value1 <= '0;
            div_value2 <= '0;
            for (int k = 0; k <= DIV_LATENCY; k++)
                tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= tag_new;
            for (int k = 1; k <= DIV_LATENCY; k++)
                tag_pipe[k] <= tag_pipe[k-1];
            if (grant) begin
                div_value1 <= sel_v1;
                div_value2 <= sel_v2;
                ptr        <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
            in_flight  <= '0;
        end else begin
            rsp_valid <= '0;
            if (tag_last.vld) begin
                rsp_valid[tag_last.id] <= 1'b1;
                rsp_result             <= div_result;
            end
            if (grant && !tag_last.vld)
                in_flight <= in_flight + 1'b1;
            else if (!grant && tag_last.vld)
                in_flight <= in_flight - 1'b1;
        end
    end

`ifdef FPDIV_SCHED_DZ_FLAG_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            rsp_dz <= 1'b0;
        else
            rsp_dz <= tag_last.vld & tag_last.dz;
    end
`else
    assign rsp_dz = 1'b0;
`endif

endmodule
